// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter for the register file's single write port, with a registered write stage.
// Define REGARB_DEBUG_PORT_EN to add the debug host as a third requester.
module regfile_write_arbiter #(
  parameter  int DATA_W   = 8,
  parameter  int NUM_REGS = 4,
  localparam int AW       = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  input  logic                alu_valid,
  input  logic [AW-1:0]       alu_reg,
  input  logic [DATA_W-1:0]   alu_data,
  output logic                alu_ready,
  input  logic                ld_valid,
  input  logic [AW-1:0]       ld_reg,
  input  logic [DATA_W-1:0]   ld_data,
  output logic                ld_ready,
`ifdef REGARB_DEBUG_PORT_EN
  input  logic                dbg_valid,
  input  logic [AW-1:0]       dbg_reg,
  input  logic [DATA_W-1:0]   dbg_data,
  output logic                dbg_ready,
`endif
  output logic                rf_we,
  output logic [AW-1:0]       rf_waddr,
  output logic [DATA_W-1:0]   rf_wdata,
  output logic [1:0]          grant_id,
  output logic [NUM_REGS-1:0] pend_mask
);

`ifdef REGARB_DEBUG_PORT_EN
  localparam int N = 3;
`else
  localparam int N = 2;
`endif

  logic [2:0]        req_valid;
  logic [2:0]        cand_sum;
  logic              gnt_valid;
  logic [1:0]        gnt_idx;
  logic [AW-1:0]     win_reg;
  logic [DATA_W-1:0] win_data;

  logic [1:0]        last_gnt_q, last_gnt_d;
  logic              rf_we_q, rf_we_d;
  logic [AW-1:0]     rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
  logic [1:0]        grant_id_q, grant_id_d;

`ifdef REGARB_DEBUG_PORT_EN
  assign req_valid = {dbg_valid, ld_valid, alu_valid};
`else
  assign req_valid = {1'b0, ld_valid, alu_valid};
`endif

  // Search starts just past the last winner; reset also blocks grants since ready is combinational.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    gnt_valid = 1'b0;
    gnt_idx   = 2'd0;
    cand_sum  = 3'd0;
    for (int k = 1; k <= N; k++) begin
      cand_sum = {1'b0, last_gnt_q} + 3'(k);
      if (cand_sum >= 3'(N)) cand_sum = cand_sum - 3'(N);
      if (!gnt_valid && req_valid[cand_sum[1:0]]) begin
        gnt_valid = 1'b1;
        gnt_idx   = cand_sum[1:0];
      end
    end
    if (stall || reset) gnt_valid = 1'b0;
  end

  assign alu_ready = gnt_valid && (gnt_idx == 2'd0);
  assign ld_ready  = gnt_valid && (gnt_idx == 2'd1);
`ifdef REGARB_DEBUG_PORT_EN
  assign dbg_ready = gnt_valid && (gnt_idx == 2'd2);
`endif

  always_comb begin
    win_reg  = alu_reg;
    win_data = alu_data;
    case (gnt_idx)
      2'd1: begin
        win_reg  = ld_reg;
        win_data = ld_data;
      end
`ifdef REGARB_DEBUG_PORT_EN
      2'd2: begin
        win_reg  = dbg_reg;
        win_data = dbg_data;
      end
`endif
      default: ;
    endcase
  end

  // Address, data and id hold between transfers; only the enable falls back to idle.
  always_comb begin
    rf_we_d    = gnt_valid;
    last_gnt_d = gnt_valid ? gnt_idx  : last_gnt_q;
    rf_waddr_d = gnt_valid ? win_reg  : rf_waddr_q;
    rf_wdata_d = gnt_valid ? win_data : rf_wdata_q;
    grant_id_d = gnt_valid ? gnt_idx  : grant_id_q;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_gnt_q <= 2'(N - 1);
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      grant_id_q <= 2'd0;
    end else begin
      last_gnt_q <= last_gnt_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      grant_id_q <= grant_id_d;
    end
  end

  assign rf_we     = rf_we_q;
  assign rf_waddr  = rf_waddr_q;
  assign rf_wdata  = rf_wdata_q;
  assign grant_id  = grant_id_q;
  assign pend_mask = rf_we_q ? (NUM_REGS'(1) << rf_waddr_q) : '0;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: vector table plus reset, debug-port and mid-reset sequences.
module tb_regfile_write_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       stall;
  logic       alu_valid, ld_valid, dbg_valid;
  logic [1:0] alu_reg, ld_reg, dbg_reg;
  logic [7:0] alu_data, ld_data, dbg_data;
  logic       alu_ready, ld_ready, dbg_ready;
  logic       rf_we;
  logic [1:0] rf_waddr;
  logic [7:0] rf_wdata;
  logic [1:0] grant_id;
  logic [3:0] pend_mask;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  regfile_write_arbiter #(.DATA_W(8), .NUM_REGS(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .stall     (stall),
    .alu_valid (alu_valid),
    .alu_reg   (alu_reg),
    .alu_data  (alu_data),
    .alu_ready (alu_ready),
    .ld_valid  (ld_valid),
    .ld_reg    (ld_reg),
    .ld_data   (ld_data),
    .ld_ready  (ld_ready),
`ifdef REGARB_DEBUG_PORT_EN
    .dbg_valid (dbg_valid),
    .dbg_reg   (dbg_reg),
    .dbg_data  (dbg_data),
    .dbg_ready (dbg_ready),
`endif
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .grant_id  (grant_id),
    .pend_mask (pend_mask)
  );

`ifndef REGARB_DEBUG_PORT_EN
  assign dbg_ready = 1'b0;
`endif

  typedef struct {
    logic       stall;
    logic       av;
    logic [1:0] ar;
    logic [7:0] ad;
    logic       lv;
    logic [1:0] lr;
    logic [7:0] ldat;
    logic       e_ardy;
    logic       e_lrdy;
    logic       e_we;
    logic [1:0] e_addr;
    logic [7:0] e_data;
    logic [1:0] e_gid;
    logic [3:0] e_pend;
  } vec_t;

  vec_t tbl [13];

  function automatic vec_t mk(input logic st, input logic av, input logic [1:0] ar, input logic [7:0] ad,
                              input logic lv, input logic [1:0] lr, input logic [7:0] ldat,
                              input logic e_ardy, input logic e_lrdy, input logic e_we,
                              input logic [1:0] e_addr, input logic [7:0] e_data,
                              input logic [1:0] e_gid, input logic [3:0] e_pend);
    vec_t v;
    v.stall = st; v.av = av; v.ar = ar; v.ad = ad; v.lv = lv; v.lr = lr; v.ldat = ldat;
    v.e_ardy = e_ardy; v.e_lrdy = e_lrdy; v.e_we = e_we; v.e_addr = e_addr;
    v.e_data = e_data; v.e_gid = e_gid; v.e_pend = e_pend;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    // Expected readys during the cycle, then rf_* after the edge that follows.
    tbl[0]  = mk(0, 1, 2'd2, 8'hA5, 0, 2'd0, 8'h00,  1, 0,  1, 2'd2, 8'hA5, 2'd0, 4'b0100);
    tbl[1]  = mk(0, 0, 2'd0, 8'h00, 0, 2'd0, 8'h00,  0, 0,  0, 2'd2, 8'hA5, 2'd0, 4'b0000);
    tbl[2]  = mk(0, 0, 2'd0, 8'h00, 1, 2'd3, 8'h3C,  0, 1,  1, 2'd3, 8'h3C, 2'd1, 4'b1000);
    tbl[3]  = mk(0, 1, 2'd1, 8'h11, 1, 2'd1, 8'h22,  1, 0,  1, 2'd1, 8'h11, 2'd0, 4'b0010);
    tbl[4]  = mk(0, 1, 2'd1, 8'h11, 1, 2'd1, 8'h22,  0, 1,  1, 2'd1, 8'h22, 2'd1, 4'b0010);
    tbl[5]  = mk(0, 1, 2'd1, 8'h11, 1, 2'd1, 8'h22,  1, 0,  1, 2'd1, 8'h11, 2'd0, 4'b0010);
    tbl[6]  = mk(0, 1, 2'd1, 8'h11, 1, 2'd1, 8'h22,  0, 1,  1, 2'd1, 8'h22, 2'd1, 4'b0010);
    tbl[7]  = mk(1, 0, 2'd0, 8'h00, 1, 2'd3, 8'h7E,  0, 0,  0, 2'd1, 8'h22, 2'd1, 4'b0000);
    tbl[8]  = mk(1, 0, 2'd0, 8'h00, 1, 2'd3, 8'h7E,  0, 0,  0, 2'd1, 8'h22, 2'd1, 4'b0000);
    tbl[9]  = mk(1, 0, 2'd0, 8'h00, 1, 2'd3, 8'h7E,  0, 0,  0, 2'd1, 8'h22, 2'd1, 4'b0000);
    tbl[10] = mk(0, 0, 2'd0, 8'h00, 1, 2'd3, 8'h7E,  0, 1,  1, 2'd3, 8'h7E, 2'd1, 4'b1000);
    tbl[11] = mk(0, 1, 2'd0, 8'h5A, 0, 2'd0, 8'h00,  1, 0,  1, 2'd0, 8'h5A, 2'd0, 4'b0001);
    tbl[12] = mk(0, 0, 2'd0, 8'h00, 0, 2'd0, 8'h00,  0, 0,  0, 2'd0, 8'h5A, 2'd0, 4'b0000);

    // Reset with every requester asserting valid.
    reset = 1'b1; stall = 1'b0;
    alu_valid = 1'b1; alu_reg = 2'd1; alu_data = 8'h99;
    ld_valid  = 1'b1; ld_reg  = 2'd2; ld_data  = 8'h88;
    dbg_valid = 1'b1; dbg_reg = 2'd3; dbg_data = 8'h77;
    repeat (2) @(posedge clk);
    #1;
    check("rst_alu_ready", alu_ready, 0);
    check("rst_ld_ready", ld_ready, 0);
    check("rst_dbg_ready", dbg_ready, 0);
    check("rst_rf_we", rf_we, 0);
    check("rst_rf_waddr", rf_waddr, 0);
    check("rst_rf_wdata", rf_wdata, 0);
    check("rst_grant_id", grant_id, 0);
    check("rst_pend_mask", pend_mask, 0);
    reset = 1'b0;
    #1;
    check("post_rst_alu_first", alu_ready, 1);
    check("post_rst_ld_waits", ld_ready, 0);
    check("post_rst_dbg_waits", dbg_ready, 0);
    alu_valid = 1'b0; ld_valid = 1'b0; dbg_valid = 1'b0;
    @(posedge clk); #1;
    check("idle_rf_we", rf_we, 0);
    check("idle_rf_wdata", rf_wdata, 0);

    foreach (tbl[i]) begin
      stall = tbl[i].stall;
      alu_valid = tbl[i].av; alu_reg = tbl[i].ar; alu_data = tbl[i].ad;
      ld_valid  = tbl[i].lv; ld_reg  = tbl[i].lr; ld_data  = tbl[i].ldat;
      #4;
      check($sformatf("v%0d_alu_ready", i), alu_ready, tbl[i].e_ardy);
      check($sformatf("v%0d_ld_ready", i), ld_ready, tbl[i].e_lrdy);
      @(posedge clk); #1;
      check($sformatf("v%0d_rf_we", i), rf_we, tbl[i].e_we);
      check($sformatf("v%0d_rf_waddr", i), rf_waddr, tbl[i].e_addr);
      check($sformatf("v%0d_rf_wdata", i), rf_wdata, tbl[i].e_data);
      check($sformatf("v%0d_grant_id", i), grant_id, tbl[i].e_gid);
      check($sformatf("v%0d_pend_mask", i), pend_mask, tbl[i].e_pend);
    end
    stall = 1'b0; alu_valid = 1'b0; ld_valid = 1'b0;

`ifdef REGARB_DEBUG_PORT_EN
    // Debug-only write moves the pointer to 2, then all three contend.
    dbg_valid = 1'b1; dbg_reg = 2'd2; dbg_data = 8'hD0;
    #4;
    check("dbg_only_ready", dbg_ready, 1);
    @(posedge clk); #1;
    check("dbg_only_gid", grant_id, 2);
    check("dbg_only_wdata", rf_wdata, 8'hD0);
    alu_valid = 1'b1; alu_reg = 2'd0; alu_data = 8'h10;
    ld_valid  = 1'b1; ld_reg  = 2'd1; ld_data  = 8'h20;
    dbg_valid = 1'b1; dbg_reg = 2'd2; dbg_data = 8'h30;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      check($sformatf("rr3_c%0d_gid", c), grant_id, c % 3);
      check($sformatf("rr3_c%0d_wdata", c), rf_wdata, 8'h10 * ((c % 3) + 1));
    end
    alu_valid = 1'b0; ld_valid = 1'b0; dbg_valid = 1'b0;
    @(posedge clk); #1;
`endif

    // Reset lands while an LD write sits in the output stage.
    ld_valid = 1'b1; ld_reg = 2'd0; ld_data = 8'hFF;
    #4;
    check("mid_ld_ready", ld_ready, 1);
    @(posedge clk); #1;
    check("mid_ld_we", rf_we, 1);
    check("mid_ld_wdata", rf_wdata, 8'hFF);
    reset = 1'b1;
    alu_valid = 1'b1; alu_reg = 2'd2; alu_data = 8'h33;
    #1;
    check("mid_rst_we_drop", rf_we, 0);
    check("mid_rst_pend", pend_mask, 0);
    check("mid_rst_alu_ready", alu_ready, 0);
    check("mid_rst_ld_ready", ld_ready, 0);
    @(posedge clk); #1;
    check("mid_rst_edge_we", rf_we, 0);
    check("mid_rst_edge_wdata", rf_wdata, 0);
    reset = 1'b0;
    #1;
    check("mid_rel_alu_first", alu_ready, 1);
    check("mid_rel_ld_waits", ld_ready, 0);
    @(posedge clk); #1;
    check("mid_rel_we", rf_we, 1);
    check("mid_rel_gid", grant_id, 0);
    check("mid_rel_waddr", rf_waddr, 2);
    check("mid_rel_wdata", rf_wdata, 8'h33);
    alu_valid = 1'b0; ld_valid = 1'b0;
    @(posedge clk); #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Arbitrates the single write port of the CPU's 4×8-bit register file among independent writeback sources: ALU writeback, load unit and, optionally, the debug host. Each requester uses a valid/ready handshake, and a work-conserving round-robin picks the winner. The winning write is registered into an output stage that drives the register file's write-enable, write-address and write-data pins. A pending-write mask tells the decode stage which registers have an in-flight write, so it can stall dependent reads.

## Interface
- `DATA_W`, default 8, register data width.
- `NUM_REGS`, default 4, register count; address width is `AW = $clog2(NUM_REGS)` = 2.
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high; clock `clk`.
- `stall`  in  1  when high, no grant is issued this cycle.
- `alu_valid` in 1, `alu_reg` in AW, `alu_data` in DATA_W, `alu_ready` out 1: requester 0.
- `ld_valid` in 1, `ld_reg` in AW, `ld_data` in DATA_W, `ld_ready` out 1: requester 1.
- `dbg_valid` in 1, `dbg_reg` in AW, `dbg_data` in DATA_W, `dbg_ready` out 1: requester 2. Present only with `REGARB_DEBUG_PORT_EN`.
- `rf_we`  out  1  register-file write enable.
- `rf_waddr`  out  AW  register-file write address.
- `rf_wdata`  out  DATA_W  register-file write data.
- `grant_id`  out  2  requester whose write is currently in `rf_*`.
- `pend_mask`  out  NUM_REGS  one-hot of `rf_waddr` while `rf_we` is high; otherwise 0.

## Operation
- Handshake:
  - A transfer occurs when `x_valid && x_ready` at a rising edge.
  - The requester holds `x_reg` and `x_data` stable while `x_valid && !x_ready`.
  - `x_ready` is combinational from the valids, `stall` and the pointer.
  - At most one `x_ready` is high per cycle.
- Arbitration:
  - `last_gnt` holds the index of the most recent transfer.
  - Search order is `last_gnt+1`, `last_gnt+2`, … modulo N, where N = 3 with the macro and 2 without.
  - The first requester with valid high is granted.
  - `last_gnt` updates only on an actual transfer.
- `stall` high forces every ready low. Valids stay pending, and `last_gnt` is unchanged.
- Output stage, on a transfer:
  - `rf_we` = 1.
  - `rf_waddr` and `rf_wdata` take the winner's reg and data.
  - `grant_id` = winner index.
- With no transfer, `rf_we` = 0 on the next cycle. `rf_waddr`, `rf_wdata` and `grant_id` hold their values.
- Same-register conflicts need no special handling. Writes are serialised in grant order, so the later grant wins in the register file.
- A requester with valid high and no competitor is granted every cycle (back-to-back, full throughput).
- `pend_mask` = `rf_we ? (1 << rf_waddr) : 0`.

## Timing
- Reset values:
  - `rf_we` = 0, `rf_waddr` = 0, `rf_wdata` = 0x00, `grant_id` = 0, `pend_mask` = 0.
  - `last_gnt` = N−1, so requester 0 has first priority.
  - All readys are 0 while reset is asserted.
- Latency:
  - Handshake at edge T: `rf_we` is high during cycle T..T+1.
  - The register file captures the write at edge T+1.
  - Readback is valid after edge T+1.
- Throughput: one write per cycle.
- Fairness: with all N requesters continuously valid, each is granted exactly once per N cycles.
- Reset mid-operation:
  - An output-stage write pending at reset assertion is dropped, not written.
  - Un-handshaken requests are not retained.
  - The first grant after deassertion goes to requester 0 if it is valid.

## Configuration
- `REGARB_DEBUG_PORT_EN` defined:
  - The `dbg_*` ports exist and N = 3.
  - The debug host shares the round-robin equally with the other requesters.
  - `last_gnt` reset value is 2.
- `REGARB_DEBUG_PORT_EN` undefined:
  - The `dbg_*` ports are absent and N = 2.
  - `last_gnt` reset value is 1.
  - `grant_id` only ever takes the values 0 and 1.

## Test plan
- Reset and idle: assert reset with all valids high.
  - All readys are 0 and `rf_we` = 0.
  - After release, the first grant goes to ALU.
  - `rf_we`, `rf_waddr`, `rf_wdata` = 0/0/0x00 before the first grant.
- Single write: `alu_valid` with reg 2, data 0xA5 for one cycle.
  - `alu_ready` = 1 that cycle.
  - Next cycle: `rf_we` = 1, `rf_waddr` = 2, `rf_wdata` = 0xA5, `pend_mask` = 4'b0100, `grant_id` = 0.
- Contention: ALU (reg 1, 0x11) and LD (reg 1, 0x22) both continuously valid for 4 cycles.
  - Grant sequence is ALU, LD, ALU, LD.
  - `rf_wdata` sequence is 0x11, 0x22, 0x11, 0x22.
- Stall: hold `stall` = 1 for 3 cycles with LD valid (reg 3, 0x7E).
  - No ready and `rf_we` = 0 for those 3 cycles.
  - LD is granted in the first cycle after `stall` drops.
- Debug port (macro defined): all three valid continuously for 6 cycles.
  - Grants are 0, 1, 2, 0, 1, 2.
  - With the macro undefined, a two-requester run alternates 0, 1.
- Reset mid-operation: assert reset on the cycle after an LD handshake (reg 0, 0xFF).
  - `rf_we` drops to 0 immediately and no write of 0xFF occurs.
  - After release, the ALU request is granted first.
